// File: rtl/usb_dfu_flash_sequencer.sv
// usb_dfu_flash_sequencer
//   Drives usb_spiflash_bridge for the DFU class handler, one DFU block per
//   flash page. A block number is mapped to a flash page at BASE_PAGE.
//   rd/wr_request is held for exactly cmd_length bytes, and the sequencer
//   waits out the erase/program busy time. A DFU status code is returned for
//   every block.
//
// Ports
//   clk, reset_n           clock, synchronous active-low reset
//   cmd_valid/cmd_ready    block command handshake (ready only when idle)
//   cmd_dir                0 = download (write flash), 1 = upload (read flash)
//   cmd_block, cmd_length  DFU block number, bytes in block (0..PAGE_SIZE)
//   done, status           one-cycle completion pulse; status is held until
//                          the next done (0x0 OK, 0x3 errWRITE, 0x8 errADDRESS)
//   busy                   high whenever the sequencer is not idle
//   flash_*                control/handshake to and from the bridge
//
// Build option
//   USB_DFU_SEQ_CHECK_EN   enforces download ordering: a session must start on
//                          a sector-aligned page and then continue with
//                          consecutive blocks.

module usb_dfu_flash_sequencer #(
    parameter int unsigned PAGE_SIZE      = 256,
    parameter int unsigned SECTOR_PAGES   = 16,
    parameter logic [15:0] BASE_PAGE      = 16'h0280,
    parameter logic [15:0] IMAGE_PAGES    = 16'h0D80,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4800000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_dir,
    input  logic [15:0] cmd_block,
    input  logic [8:0]  cmd_length,
    output logic        done,
    output logic [3:0]  status,
    output logic        busy,
    output logic [15:0] flash_address,
    output logic        flash_rd_request,
    output logic        flash_wr_request,
    input  logic        flash_wr_busy,
    input  logic        flash_rd_data_put,
    input  logic        flash_wr_data_get
);

    typedef enum logic [2:0] {
        IDLE, CHECK, WR_XFER, WR_WAIT, RD_XFER, DRAIN, DONE
    } state_t;

    localparam logic [3:0] ST_OK        = 4'h0;
    localparam logic [3:0] ST_ERR_WRITE = 4'h3;
    localparam logic [3:0] ST_ERR_ADDR  = 4'h8;
    localparam logic [8:0] MAX_LEN      = 9'(PAGE_SIZE);

    state_t      state;
    logic        dir_q;
    logic [15:0] block_q;
    logic [8:0]  len_q;
    logic [8:0]  byte_cnt;
    logic [23:0] timer;
    logic        seen_busy;
    logic [15:0] page_sum;

    // 16-bit page address; it wraps if BASE_PAGE + block overflows.
    assign page_sum = BASE_PAGE + block_q;

`ifdef USB_DFU_SEQ_CHECK_EN
    logic        session_active;
    logic [15:0] last_block;
    logic        seq_ok;

    always_comb begin
        seq_ok = 1'b1;
        if (!session_active)
            seq_ok = ((32'(page_sum) % SECTOR_PAGES) == 32'd0);
        else
            seq_ok = (block_q == last_block + 16'd1);
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            cmd_ready        <= 1'b1;
            done             <= 1'b0;
            status           <= ST_OK;
            busy             <= 1'b0;
            flash_address    <= '0;
            flash_rd_request <= 1'b0;
            flash_wr_request <= 1'b0;
            dir_q            <= 1'b0;
            block_q          <= '0;
            len_q            <= '0;
            byte_cnt         <= '0;
            timer            <= '0;
            seen_busy        <= 1'b0;
`ifdef USB_DFU_SEQ_CHECK_EN
            session_active   <= 1'b0;
            last_block       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // cmd_ready is high only here, so cmd_valid alone is an accept.
                    if (cmd_valid) begin
                        dir_q     <= cmd_dir;
                        block_q   <= cmd_block;
                        // The bridge moves at most one page per request.
                        len_q     <= (cmd_length > MAX_LEN) ? MAX_LEN : cmd_length;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    byte_cnt  <= '0;
                    timer     <= '0;
                    seen_busy <= 1'b0;
                    if (len_q == 9'd0) begin
                        status <= ST_OK;
                        done   <= 1'b1;
                        state  <= DONE;
`ifdef USB_DFU_SEQ_CHECK_EN
                        session_active <= 1'b0;
`endif
                    end else if (block_q >= IMAGE_PAGES) begin
                        status <= ST_ERR_ADDR;
                        done   <= 1'b1;
                        state  <= DONE;
`ifdef USB_DFU_SEQ_CHECK_EN
                        session_active <= 1'b0;
                    end else if (!dir_q && !seq_ok) begin
                        status <= ST_ERR_ADDR;
                        done   <= 1'b1;
                        state  <= DONE;
                        session_active <= 1'b0;
`endif
                    end else begin
                        flash_address <= page_sum;
                        if (dir_q) begin
                            flash_rd_request <= 1'b1;
                            state            <= RD_XFER;
`ifdef USB_DFU_SEQ_CHECK_EN
                            session_active   <= 1'b0;
`endif
                        end else begin
                            flash_wr_request <= 1'b1;
                            state            <= WR_XFER;
                        end
                    end
                end
                WR_XFER: begin
                    timer <= timer + 24'd1;
                    // Busy may already rise while the last bytes are moving.
                    if (flash_wr_busy)
                        seen_busy <= 1'b1;
                    if (flash_wr_data_get) begin
                        byte_cnt <= byte_cnt + 9'd1;
                        if (byte_cnt + 9'd1 == len_q) begin
                            flash_wr_request <= 1'b0;
                            timer            <= '0;
                            state            <= WR_WAIT;
                        end
                    end
                    if (timer == TIMEOUT_CYCLES && !(flash_wr_data_get && byte_cnt + 9'd1 == len_q)) begin
                        flash_wr_request <= 1'b0;
                        state            <= DRAIN;
`ifdef USB_DFU_SEQ_CHECK_EN
                        session_active   <= 1'b0;
`endif
                    end
                end
                WR_WAIT: begin
                    timer <= timer + 24'd1;
                    if (flash_wr_busy)
                        seen_busy <= 1'b1;
                    if (seen_busy && !flash_wr_busy) begin
                        status <= ST_OK;
                        done   <= 1'b1;
                        state  <= DONE;
`ifdef USB_DFU_SEQ_CHECK_EN
                        session_active <= 1'b1;
                        last_block     <= block_q;
`endif
                    end else if (timer == TIMEOUT_CYCLES) begin
                        state <= DRAIN;
`ifdef USB_DFU_SEQ_CHECK_EN
                        session_active <= 1'b0;
`endif
                    end
                end
                RD_XFER: begin
                    timer <= timer + 24'd1;
                    if (flash_rd_data_put && byte_cnt + 9'd1 == len_q) begin
                        byte_cnt         <= byte_cnt + 9'd1;
                        flash_rd_request <= 1'b0;
                        status           <= ST_OK;
                        done             <= 1'b1;
                        state            <= DONE;
                    end else if (timer == TIMEOUT_CYCLES) begin
                        flash_rd_request <= 1'b0;
                        state            <= DRAIN;
`ifdef USB_DFU_SEQ_CHECK_EN
                        session_active   <= 1'b0;
`endif
                    end else if (flash_rd_data_put) begin
                        byte_cnt <= byte_cnt + 9'd1;
                    end
                end
                DRAIN: begin
                    // Let any erase/program in flight finish before reporting.
                    if (!flash_wr_busy) begin
                        status <= ST_ERR_WRITE;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_dfu_flash_sequencer.sv
module tb_usb_dfu_flash_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_block = '0;
    logic [8:0]  cmd_length = '0;
    logic        flash_wr_busy = 1'b0;
    logic        flash_rd_data_put = 1'b0;
    logic        flash_wr_data_get = 1'b0;
    logic        cmd_ready, done, busy, flash_rd_request, flash_wr_request;
    logic [3:0]  status;
    logic [15:0] flash_address;

    localparam int TMO = 1000;
`ifdef USB_DFU_SEQ_CHECK_EN
    localparam logic [3:0] SEQ_ERR = 4'h8;
`else
    localparam logic [3:0] SEQ_ERR = 4'h0;
`endif

    usb_dfu_flash_sequencer #(
        .TIMEOUT_CYCLES(24'(TMO))
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_block(cmd_block), .cmd_length(cmd_length),
        .done(done), .status(status), .busy(busy),
        .flash_address(flash_address),
        .flash_rd_request(flash_rd_request), .flash_wr_request(flash_wr_request),
        .flash_wr_busy(flash_wr_busy), .flash_rd_data_put(flash_rd_data_put),
        .flash_wr_data_get(flash_wr_data_get)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Scoreboard: expectations pushed at issue, popped when done appears.
    logic [3:0]  exp_status_q[$];
    logic [15:0] exp_addr_q[$];

    // Observations from the last run_bridge call.
    bit          r_done, r_addr_unstable, r_both_hi;
    logic [3:0]  r_status;
    logic [15:0] r_addr;
    int          r_done_cyc, r_xfers, r_first_req, r_req_cycles, r_busy_cnt, r_fall_cyc;

    // Presents a command at a negedge and holds it until accepted. Returns at
    // the negedge of the CHECK cycle (cycle 1), with the fields scrambled.
    task automatic issue(input logic dir, input logic [15:0] blk, input logic [8:0] len, output bit ok);
        int n = 0;
        cmd_valid = 1'b1; cmd_dir = dir; cmd_block = blk; cmd_length = len;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        ok = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_block = 16'($urandom); cmd_length = 9'($urandom); cmd_dir = 1'($urandom);
    endtask

    // Bridge model: one byte every other cycle while a request is high (when
    // feed is set), and wr_busy held for busy_cycles after a write request
    // drops. Runs until done or the cycle bound runs out.
    task automatic run_bridge(input int busy_cycles, input bit feed, input int limit);
        bit tog = 1'b0;
        bit wr_prev = 1'b0;
        int busy_left = 0;
        r_done = 0; r_status = 'x; r_addr = 'x; r_addr_unstable = 0; r_both_hi = 0;
        r_done_cyc = -1; r_xfers = 0; r_first_req = -1; r_req_cycles = 0;
        r_busy_cnt = 0; r_fall_cyc = -1;
        for (int c = 1; c <= limit; c++) begin
            if (busy) r_busy_cnt++;
            if (flash_wr_request && flash_rd_request) r_both_hi = 1;
            if (flash_wr_request || flash_rd_request) begin
                if (r_first_req < 0) begin r_first_req = c; r_addr = flash_address; end
                else if (flash_address !== r_addr) r_addr_unstable = 1;
                r_req_cycles++;
            end
            if (done) begin r_done = 1; r_status = status; r_done_cyc = c; break; end
            if (wr_prev && !flash_wr_request) busy_left = busy_cycles;
            if (busy_left > 0) begin
                flash_wr_busy = 1'b1; busy_left--;
            end else begin
                if (flash_wr_busy) r_fall_cyc = c;
                flash_wr_busy = 1'b0;
            end
            if (flash_wr_request || flash_rd_request) tog = ~tog; else tog = 1'b0;
            flash_wr_data_get = feed && flash_wr_request && tog;
            flash_rd_data_put = feed && flash_rd_request && tog;
            if (flash_wr_data_get || flash_rd_data_put) r_xfers++;
            wr_prev = flash_wr_request;
            @(negedge clk);
        end
        flash_wr_data_get = 1'b0;
        flash_rd_data_put = 1'b0;
        flash_wr_busy = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin fails++;
            $display("FAIL rst_ctrl: ready=%b busy=%b done=%b want 1 0 0", cmd_ready, busy, done); end
        checks++; if (status !== 4'h0 || flash_address !== 16'h0) begin fails++;
            $display("FAIL rst_data: status=%h addr=%h want 0 0000", status, flash_address); end
        checks++; if (flash_rd_request !== 1'b0 || flash_wr_request !== 1'b0) begin fails++;
            $display("FAIL rst_req: rd=%b wr=%b want 0 0", flash_rd_request, flash_wr_request); end
    endtask

    task automatic test_download();
        bit ok; logic [3:0] es; logic [15:0] ea;
        exp_status_q.push_back(4'h0); exp_addr_q.push_back(16'h0280);
        issue(1'b0, 16'd0, 9'd256, ok);
        run_bridge(50, 1'b1, 2000);
        es = exp_status_q.pop_front(); ea = exp_addr_q.pop_front();
        checks++; if (!ok || !r_done || r_status !== es) begin fails++;
            $display("FAIL dl_status: accepted=%b done=%b status=%h want %h", ok, r_done, r_status, es); end
        checks++; if (r_addr !== ea || r_addr_unstable) begin fails++;
            $display("FAIL dl_addr: got %h unstable=%b want %h", r_addr, r_addr_unstable, ea); end
        checks++; if (r_xfers !== 256 || r_first_req !== 2) begin fails++;
            $display("FAIL dl_bytes: gets=%0d first_req=%0d want 256 2", r_xfers, r_first_req); end
        checks++; if (r_fall_cyc < 0 || r_done_cyc !== r_fall_cyc + 1) begin fails++;
            $display("FAIL dl_wait: done at %0d busy fell at %0d want fall+1", r_done_cyc, r_fall_cyc); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin fails++;
            $display("FAIL dl_after: done=%b busy=%b ready=%b want 0 0 1", done, busy, cmd_ready); end
    endtask

    task automatic test_upload();
        bit ok; logic [3:0] es; logic [15:0] ea;
        exp_status_q.push_back(4'h0); exp_addr_q.push_back(16'h0283);
        issue(1'b1, 16'd3, 9'd100, ok);
        run_bridge(0, 1'b1, 1000);
        es = exp_status_q.pop_front(); ea = exp_addr_q.pop_front();
        checks++; if (!ok || !r_done || r_status !== es) begin fails++;
            $display("FAIL ul_status: accepted=%b done=%b status=%h want %h", ok, r_done, r_status, es); end
        checks++; if (r_addr !== ea || r_addr_unstable) begin fails++;
            $display("FAIL ul_addr: got %h unstable=%b want %h", r_addr, r_addr_unstable, ea); end
        checks++; if (r_xfers !== 100 || r_done_cyc !== 201 || r_both_hi) begin fails++;
            $display("FAIL ul_bytes: puts=%0d done_cyc=%0d both=%b want 100 201 0", r_xfers, r_done_cyc, r_both_hi); end
    endtask

    task automatic test_addr_error();
        bit ok; logic [3:0] es;
        exp_status_q.push_back(4'h8);
        issue(1'b0, 16'h0D80, 9'd256, ok);
        run_bridge(0, 1'b1, 50);
        es = exp_status_q.pop_front();
        checks++; if (!ok || !r_done || r_status !== es) begin fails++;
            $display("FAIL aerr_status: done=%b status=%h want %h", r_done, r_status, es); end
        checks++; if (r_first_req !== -1 || r_done_cyc !== 2) begin fails++;
            $display("FAIL aerr_timing: first_req=%0d done_cyc=%0d want -1 2", r_first_req, r_done_cyc); end
    endtask

    task automatic test_zero_length();
        bit ok; logic [3:0] es;
        exp_status_q.push_back(4'h0);
        issue(1'b0, 16'd5, 9'd0, ok);
        run_bridge(0, 1'b1, 50);
        es = exp_status_q.pop_front();
        checks++; if (!ok || !r_done || r_status !== es) begin fails++;
            $display("FAIL zl_status: done=%b status=%h want %h", r_done, r_status, es); end
        checks++; if (r_first_req !== -1 || r_done_cyc !== 2 || r_busy_cnt !== 2) begin fails++;
            $display("FAIL zl_timing: first_req=%0d done_cyc=%0d busy_cycles=%0d want -1 2 2",
                     r_first_req, r_done_cyc, r_busy_cnt); end
    endtask

    task automatic test_last_block();
        bit ok; logic [3:0] es; logic [15:0] ea;
        exp_status_q.push_back(4'h0); exp_addr_q.push_back(16'h0FFF);
        issue(1'b1, 16'h0D7F, 9'd1, ok);
        run_bridge(0, 1'b1, 50);
        es = exp_status_q.pop_front(); ea = exp_addr_q.pop_front();
        checks++; if (!r_done || r_status !== es || r_addr !== ea || r_xfers !== 1) begin fails++;
            $display("FAIL last_blk: done=%b status=%h addr=%h puts=%0d want %h %h 1",
                     r_done, r_status, r_addr, r_xfers, es, ea); end
    endtask

    task automatic test_write_timeout();
        bit ok; logic [3:0] es;
        exp_status_q.push_back(4'h3);
        issue(1'b0, 16'd16, 9'd8, ok);
        run_bridge(3000, 1'b1, 5000);
        es = exp_status_q.pop_front();
        checks++; if (!ok || !r_done || r_status !== es) begin fails++;
            $display("FAIL wto_status: done=%b status=%h want %h", r_done, r_status, es); end
        checks++; if (r_fall_cyc < 0 || r_done_cyc !== r_fall_cyc + 1 || r_xfers !== 8) begin fails++;
            $display("FAIL wto_drain: done at %0d busy fell at %0d gets=%0d want fall+1, 8",
                     r_done_cyc, r_fall_cyc, r_xfers); end
    endtask

    task automatic test_read_timeout();
        bit ok; logic [3:0] es;
        exp_status_q.push_back(4'h3);
        issue(1'b1, 16'd2, 9'd10, ok);
        run_bridge(0, 1'b0, 3000);
        es = exp_status_q.pop_front();
        checks++; if (!ok || !r_done || r_status !== es) begin fails++;
            $display("FAIL rto_status: done=%b status=%h want %h", r_done, r_status, es); end
        checks++; if (r_req_cycles < TMO || r_req_cycles > TMO + 2 || r_done_cyc > r_req_cycles + 4) begin fails++;
            $display("FAIL rto_req: req_cycles=%0d done_cyc=%0d want %0d..%0d", r_req_cycles, r_done_cyc, TMO, TMO + 2); end
    endtask

    task automatic test_back_to_back();
        bit ok; logic [3:0] es; logic [15:0] ea;
        exp_status_q.push_back(4'h0); exp_addr_q.push_back(16'h0283);
        exp_status_q.push_back(4'h0); exp_addr_q.push_back(16'h0287);
        issue(1'b1, 16'd3, 9'd4, ok);
        // Second command waits on the bus for the whole first transfer.
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_block = 16'd7; cmd_length = 9'd2;
        run_bridge(0, 1'b1, 100);
        es = exp_status_q.pop_front(); ea = exp_addr_q.pop_front();
        checks++; if (!r_done || r_status !== es || r_addr !== ea || r_addr_unstable || r_xfers !== 4) begin fails++;
            $display("FAIL b2b_first: done=%b status=%h addr=%h unstable=%b puts=%0d want %h %h 0 4",
                     r_done, r_status, r_addr, r_addr_unstable, r_xfers, es, ea); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin fails++;
            $display("FAIL b2b_ready: ready=%b want 1 on cycle after done", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_block = 16'hBEEF; cmd_length = 9'd77; cmd_dir = 1'b0;
        run_bridge(0, 1'b1, 100);
        es = exp_status_q.pop_front(); ea = exp_addr_q.pop_front();
        checks++; if (!r_done || r_status !== es || r_addr !== ea || r_xfers !== 2 || r_done_cyc !== 5) begin fails++;
            $display("FAIL b2b_second: done=%b status=%h addr=%h puts=%0d done_cyc=%0d want %h %h 2 5",
                     r_done, r_status, r_addr, r_xfers, r_done_cyc, es, ea); end
    endtask

    task automatic test_session();
        logic [15:0] blks [5];
        logic [3:0]  want [5];
        bit ok; logic [3:0] es; int exp_first;
        blks = '{16'd0, 16'd1, 16'd5, 16'd16, 16'd18};
        want = '{4'h0, 4'h0, SEQ_ERR, 4'h0, SEQ_ERR};
        for (int i = 0; i < 5; i++) begin
            exp_status_q.push_back(want[i]);
            issue(1'b0, blks[i], 9'd4, ok);
            run_bridge(5, 1'b1, 200);
            es = exp_status_q.pop_front();
            exp_first = (es == 4'h0) ? 2 : -1;
            checks++; if (!r_done || r_status !== es || r_first_req !== exp_first) begin fails++;
                $display("FAIL seq_blk%0d: done=%b status=%h first_req=%0d want %h %0d",
                         blks[i], r_done, r_status, r_first_req, es, exp_first); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int n = 0; int dones = 0;
        issue(1'b0, 16'd32, 9'd16, ok);
        while (!flash_wr_request && n < 10) begin @(negedge clk); n++; end
        reset_n = 1'b0;
        @(negedge clk);
        if (done) dones++;
        checks++; if (!ok || flash_wr_request !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin fails++;
            $display("FAIL rmid_drop: wr_req=%b ready=%b busy=%b want 0 1 0", flash_wr_request, cmd_ready, busy); end
        reset_n = 1'b1;
        repeat (5) begin @(negedge clk); if (done) dones++; end
        checks++; if (dones !== 0 || status !== 4'h0) begin fails++;
            $display("FAIL rmid_done: done pulses=%0d status=%h want 0 0", dones, status); end
    endtask

    initial begin
        test_reset();
        test_download();
        test_upload();
        test_addr_error();
        test_zero_length();
        test_last_block();
        test_write_timeout();
        test_read_timeout();
        test_back_to_back();
        test_session();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
